// File: rtl/regfile_trace_monitor.sv
// regfile_trace_monitor
//   Snoops the WB-stage regfile write port. Writes to watched registers are
//   stamped with a free-running cycle count and pushed into a trace FIFO.
//   An optional data-match trigger captures a fixed number of further writes
//   and then freezes the trace. Entries drain over a valid/ready port.
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   arm                          flush FIFO, clear overflow, start capture
//   trig_en/trig_reg/trig_val    data-match trigger setup
//   wr_en/wr_addr/wr_data        snooped regfile write port
//   out_valid/out_ready          FIFO head handshake (first-word fall-through)
//   out_cycle/out_addr/out_data  FIFO head entry (zero when empty)
//   count                        entries held
//   overflow                     sticky: a qualifying write was dropped
//   state                        0 IDLE, 1 CAPTURE, 2 POST, 3 FROZEN
//
// state   | meaning
// IDLE    | after reset, nothing captured until arm
// CAPTURE | capturing watched writes, looking for the trigger
// POST    | trigger seen, capturing post_cnt more writes
// FROZEN  | capture stopped, draining only
module regfile_trace_monitor #(
  parameter int                    DATA_W     = 32,
  parameter int                    ADDR_W     = 5,
  parameter int                    DEPTH      = 16,
  parameter int                    CYC_W      = 16,
  parameter logic [2**ADDR_W-1:0]  WATCH_MASK = 32'h03FF_FF00,
  parameter int                    POST_TRIG  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  input  logic                       trig_en,
  input  logic [ADDR_W-1:0]          trig_reg,
  input  logic [DATA_W-1:0]          trig_val,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CYC_W-1:0]           out_cycle,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [1:0]                 state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PT_W  = (POST_TRIG < 1) ? 1 : $clog2(POST_TRIG + 1);
  localparam int ENT_W = CYC_W + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    POST    = 2'd2,
    FROZEN  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PT_W-1:0]   post_cnt_q, post_cnt_d;
  logic [CYC_W-1:0]  cyc_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              overflow_q;
  logic [ENT_W-1:0]  mem [DEPTH];

  logic qual, trig_hit, pop, push, drop;

  assign qual = wr_en && WATCH_MASK[wr_addr] && (wr_addr != '0) &&
                ((state_q == CAPTURE) || (state_q == POST));
  assign trig_hit = qual && trig_en && (wr_addr == trig_reg) && (wr_data == trig_val);
  assign pop  = (cnt_q != '0) && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push = qual && ((cnt_q < CNT_W'(DEPTH)) || pop);
  assign drop = qual && !push;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      post_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      post_cnt_q <= post_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    post_cnt_d = post_cnt_q;
    case (state_q)
      IDLE: ;
      CAPTURE: begin
        if (trig_hit) begin
          post_cnt_d = PT_W'(POST_TRIG);
          state_d    = (POST_TRIG > 0) ? POST : FROZEN;
        end
      end
      POST: begin
        // Dropped writes still count towards the post-trigger window.
        if (qual) begin
          post_cnt_d = post_cnt_q - 1'b1;
          if (post_cnt_q == PT_W'(1)) state_d = FROZEN;
        end
      end
      FROZEN: ;
      default: state_d = IDLE;
    endcase
    if (arm) begin
      state_d    = CAPTURE;
      post_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || arm) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr_q] <= {cyc_q, wr_addr, wr_data};
        wr_ptr_q      <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      if (drop) overflow_q <= 1'b1;
    end
  end

  logic [ENT_W-1:0] head;
  assign head      = (cnt_q != '0) ? mem[rd_ptr_q] : '0;
  assign out_valid = (cnt_q != '0);
  assign out_cycle = head[ENT_W-1 -: CYC_W];
  assign out_addr  = head[DATA_W +: ADDR_W];
  assign out_data  = head[DATA_W-1:0];
  assign count     = cnt_q;
  assign overflow  = overflow_q;
  assign state     = state_q;

endmodule

// File: tb/tb_regfile_trace_monitor.sv
module tb_regfile_trace_monitor;

  logic        clk = 1'b0;
  logic        rst, arm, trig_en, wr_en, out_ready;
  logic [4:0]  trig_reg, wr_addr;
  logic [31:0] trig_val, wr_data;
  logic        out_valid, overflow;
  logic [15:0] out_cycle;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic [4:0]  count;
  logic [1:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_trace_monitor dut (
    .clk(clk), .rst(rst), .arm(arm), .trig_en(trig_en), .trig_reg(trig_reg),
    .trig_val(trig_val), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_cycle(out_cycle),
    .out_addr(out_addr), .out_data(out_data), .count(count),
    .overflow(overflow), .state(state)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arm = 0; wr_en = 0; wr_addr = 0; wr_data = 0; out_ready = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic do_arm();
    arm = 1;
    tick();
    arm = 0;
  endtask

  initial begin
    rst = 1; trig_en = 0; trig_reg = 0; trig_val = 0;
    idle_inputs();
    tick();
    // reset state
    chk("rst_state", state, 0);
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", out_data, 0);
    rst = 0;

    // 1: arm at cycle 0->1, write r8=5 while counter reads 3
    do_arm();                   // counter now 1
    chk("t1_state", state, 1);
    tick(); tick();             // counter now 3
    wr(8, 5);
    chk("t1_valid", out_valid, 1);
    chk("t1_addr", out_addr, 8);
    chk("t1_data", out_data, 5);
    chk("t1_cycle", out_cycle, 3);
    chk("t1_count", count, 1);
    out_ready = 1; tick(); out_ready = 0;
    chk("t1_drain", count, 0);

    // 2: unwatched / r0 writes ignored
    wr(0, 1); wr(1, 2); wr(26, 3);
    chk("t2_count", count, 0);
    chk("t2_ovf", overflow, 0);

    // 3: overfill with out_ready low
    for (int i = 0; i < 17; i++) wr(9, 100 + i);
    chk("t3_count", count, 16);
    chk("t3_ovf", overflow, 1);
    chk("t3_head", out_data, 100);
    // arm with a concurrent write and ready: both discarded
    arm = 1; wr_en = 1; wr_addr = 9; wr_data = 999; out_ready = 1;
    tick();
    idle_inputs();
    chk("t3_arm_count", count, 0);
    chk("t3_arm_ovf", overflow, 0);
    chk("t3_arm_valid", out_valid, 0);

    // 5: full FIFO, pop and push together
    for (int i = 0; i < 16; i++) wr(9, 200 + i);
    chk("t5_full", count, 16);
    out_ready = 1; wr(9, 300);
    chk("t5_count", count, 16);
    chk("t5_ovf", overflow, 0);
    for (int i = 1; i < 17; i++) begin
      chk("t5_order", out_data, (i < 16) ? 200 + i : 300);
      tick();
    end
    out_ready = 0;
    chk("t5_empty", count, 0);

    // 4: trigger r16=0xDEAD with 4 post writes
    do_arm();
    trig_en = 1; trig_reg = 16; trig_val = 32'hDEAD;
    wr(26, 32'hDEAD);           // unwatched, cannot trigger
    chk("t4_notrig", state, 1);
    wr(16, 32'hDEAD);
    chk("t4_post", state, 2);
    chk("t4_cnt1", count, 1);
    for (int i = 1; i <= 6; i++) begin
      wr(17, i);
      if (i == 3) chk("t4_still_post", state, 2);
    end
    chk("t4_frozen", state, 3);
    chk("t4_count", count, 5);
    out_ready = 1;
    chk("t4_e0", out_data, 32'hDEAD);
    chk("t4_e0a", out_addr, 16);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t4_post_data", out_data, i);
    end
    tick();
    out_ready = 0;
    chk("t4_drained", count, 0);

    // 6: reset in POST with 3 entries
    do_arm();
    wr(16, 32'hDEAD); wr(17, 7); wr(17, 8);
    chk("t6_state_pre", state, 2);
    chk("t6_count_pre", count, 3);
    rst = 1; arm = 1; tick(); rst = 0; arm = 0;
    chk("t6_state", state, 0);
    chk("t6_count", count, 0);
    chk("t6_valid", out_valid, 0);
    wr(9, 1);                   // IDLE: ignored
    chk("t6_idle", count, 0);
    trig_en = 0;
    rst = 1; tick(); rst = 0;   // counter 0
    do_arm();                   // counter 1
    wr(10, 42);
    chk("t6_cycle", out_cycle, 1);
    chk("t6_data", out_data, 42);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
